// File: rtl/lfsr_state_generator.sv
// Multi-channel pseudo-random two-level strobe generator: each channel alternates
// low/high phases whose lengths are drawn from per-channel Galois LFSRs.
module lfsr_state_generator #(
  parameter int unsigned CHANNEL_NUM = 4,
  parameter int unsigned CNT_WIDTH   = 8,
  parameter logic [31:0] SEED        = 32'hACE1_1234
) (
  input  logic                     i_clk,
  input  logic                     i_s_rst,
  input  logic                     i_en,
  input  logic [2*CHANNEL_NUM-1:0] i_mode,
  input  logic [CNT_WIDTH-1:0]     i_s0_min,
  input  logic [CNT_WIDTH-1:0]     i_s0_max,
  input  logic [CNT_WIDTH-1:0]     i_s1_min,
  input  logic [CNT_WIDTH-1:0]     i_s1_max,
  output logic [CHANNEL_NUM-1:0]   o_state,
  output logic [CHANNEL_NUM-1:0]   o_edge,
  output logic                     o_cfg_err
);

  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

  typedef enum logic [1:0] {
    MODE_RANDOM     = 2'b00,
    MODE_FORCE_LOW  = 2'b01,
    MODE_FORCE_HIGH = 2'b10,
    MODE_FIXED      = 2'b11
  } mode_e;

  function automatic logic [31:0] lfsr_step(input logic [31:0] l);
    return {1'b0, l[31:1]} ^ (l[0] ? LFSR_MASK : '0);
  endfunction

  function automatic logic [31:0] chan_seed(input int unsigned k);
    logic [31:0] s;
    s = SEED ^ (k * 32'h9E37_79B9);
    return (s == '0) ? 32'h1 : s;
  endfunction

  // Fold the LFSR bits into [mn, mx] with a power-of-two mask and one wrap step.
  function automatic logic [CNT_WIDTH-1:0] draw_map(input logic [31:0]          l,
                                                    input logic [CNT_WIDTH-1:0] mn,
                                                    input logic [CNT_WIDTH-1:0] mx);
    logic [CNT_WIDTH-1:0] range;
    logic [CNT_WIDTH-1:0] msk;
    logic [CNT_WIDTH-1:0] r;
    if (mn > mx) return mn;
    range = mx - mn;
    msk   = range;
    for (int unsigned s = 1; s < CNT_WIDTH; s = s * 2) msk = msk | (msk >> s);
    r = l[CNT_WIDTH-1:0] & msk;
    if (r > range) r = r - range - CNT_WIDTH'(1);
    return mn + r;
  endfunction

  mode_e                chan_mode [CHANNEL_NUM];
  logic [31:0]          lfsr_q    [CHANNEL_NUM];
  logic [31:0]          lfsr_d    [CHANNEL_NUM];
  logic [CNT_WIDTH-1:0] cnt_q     [CHANNEL_NUM];
  logic [CNT_WIDTH-1:0] cnt_d     [CHANNEL_NUM];
  logic [CNT_WIDTH-1:0] limit_q   [CHANNEL_NUM];
  logic [CNT_WIDTH-1:0] limit_d   [CHANNEL_NUM];
  logic [CHANNEL_NUM-1:0] phase_q, phase_d;
  logic [CHANNEL_NUM-1:0] edge_q, edge_d;
  logic [CHANNEL_NUM-1:0] forced_q, forced_d;
  logic                 draw_ph;
  logic [CNT_WIDTH-1:0] draw_min;
  logic [CNT_WIDTH-1:0] draw_max;

  always_comb begin
    for (int unsigned k = 0; k < CHANNEL_NUM; k++) begin
      chan_mode[k] = mode_e'(i_mode[2*k +: 2]);
    end
  end

  always_comb begin
    phase_d  = phase_q;
    edge_d   = '0;
    forced_d = forced_q;
    draw_ph  = 1'b0;
    draw_min = '0;
    draw_max = '0;
    for (int unsigned k = 0; k < CHANNEL_NUM; k++) begin
      lfsr_d[k]  = lfsr_q[k];
      cnt_d[k]   = cnt_q[k];
      limit_d[k] = limit_q[k];
      unique case (chan_mode[k])
        MODE_FORCE_LOW, MODE_FORCE_HIGH: begin
          phase_d[k]  = (chan_mode[k] == MODE_FORCE_HIGH);
          edge_d[k]   = phase_d[k] ^ phase_q[k];
          cnt_d[k]    = '0;
          forced_d[k] = 1'b1;
        end
        default: begin
          if (i_en) begin
            if (forced_q[k] || (cnt_q[k] == limit_q[k])) begin
              // Leaving a forced mode restarts the current level; normal expiry toggles it.
              draw_ph     = forced_q[k] ? phase_q[k] : ~phase_q[k];
              draw_min    = draw_ph ? i_s1_min : i_s0_min;
              draw_max    = draw_ph ? i_s1_max : i_s0_max;
              phase_d[k]  = draw_ph;
              edge_d[k]   = ~forced_q[k];
              forced_d[k] = 1'b0;
              cnt_d[k]    = '0;
              if (chan_mode[k] == MODE_FIXED) begin
                limit_d[k] = draw_min;
              end else begin
                limit_d[k] = draw_map(lfsr_q[k], draw_min, draw_max);
                lfsr_d[k]  = lfsr_step(lfsr_q[k]);
              end
            end else begin
              cnt_d[k] = cnt_q[k] + CNT_WIDTH'(1);
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_s_rst) begin
      for (int unsigned k = 0; k < CHANNEL_NUM; k++) begin
        lfsr_q[k]  <= lfsr_step(chan_seed(k));
        limit_q[k] <= draw_map(chan_seed(k), i_s0_min, i_s0_max);
        cnt_q[k]   <= '0;
      end
      phase_q  <= '0;
      edge_q   <= '0;
      forced_q <= '0;
    end else begin
      for (int unsigned k = 0; k < CHANNEL_NUM; k++) begin
        lfsr_q[k]  <= lfsr_d[k];
        limit_q[k] <= limit_d[k];
        cnt_q[k]   <= cnt_d[k];
      end
      phase_q  <= phase_d;
      edge_q   <= edge_d;
      forced_q <= forced_d;
    end
  end

  assign o_state   = phase_q;
  assign o_edge    = edge_q;
  assign o_cfg_err = (i_s0_min > i_s0_max) || (i_s1_min > i_s1_max);

endmodule

// File: tb/tb_lfsr_state_generator.sv
// Self-checking bench for lfsr_state_generator: vector table, run-length sequences
// and randomized stimulus against a countdown-based reference model.
module tb_lfsr_state_generator;

  localparam int          CH   = 4;
  localparam int          CW   = 8;
  localparam logic [31:0] SEED = 32'hACE1_1234;

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic [2*CH-1:0] mode;
  logic [CW-1:0]   s0min, s0max, s1min, s1max;
  logic [CH-1:0]   st, ed;
  logic            err;

  always #5 clk = ~clk;

  lfsr_state_generator #(
    .CHANNEL_NUM(CH),
    .CNT_WIDTH  (CW),
    .SEED       (SEED)
  ) dut (
    .i_clk    (clk),
    .i_s_rst  (rst),
    .i_en     (en),
    .i_mode   (mode),
    .i_s0_min (s0min),
    .i_s0_max (s0max),
    .i_s1_min (s1min),
    .i_s1_max (s1max),
    .o_state  (st),
    .o_edge   (ed),
    .o_cfg_err(err)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: level plus edges remaining before the next toggle.
  bit [31:0] m_lfsr   [CH];
  bit        m_level  [CH];
  int        m_rem    [CH];
  bit        m_forced [CH];
  bit        m_edge   [CH];

  function automatic bit [31:0] galois(input bit [31:0] x);
    return x[0] ? ((x >> 1) ^ 32'h8020_0003) : (x >> 1);
  endfunction

  function automatic bit [31:0] seed_of(input int c);
    longint p;
    bit [31:0] s;
    p = (longint'(c) * 64'h9E37_79B9) & 64'hFFFF_FFFF;
    s = SEED ^ p[31:0];
    return (s == 0) ? 32'h1 : s;
  endfunction

  function automatic int pick(input bit [31:0] l, input int mn, input int mx);
    int range, m, r;
    if (mn > mx) return mn;
    range = mx - mn;
    m = 0;
    while (m < range) m = m * 2 + 1;
    r = int'(l & ((32'h1 << CW) - 1)) & m;
    if (r > range) r = r - range - 1;
    return mn + r;
  endfunction

  task automatic draw(input int c, input int md, input bit lvl, output int lim);
    int mn, mx;
    mn = lvl ? int'(s1min) : int'(s0min);
    mx = lvl ? int'(s1max) : int'(s0max);
    if (md == 3) begin
      lim = mn;
    end else begin
      lim = pick(m_lfsr[c], mn, mx);
      m_lfsr[c] = galois(m_lfsr[c]);
    end
  endtask

  task automatic model_step();
    for (int c = 0; c < CH; c++) begin
      int md;
      int lim;
      md = int'(mode[2*c +: 2]);
      m_edge[c] = 1'b0;
      if (rst) begin
        m_rem[c]    = pick(seed_of(c), int'(s0min), int'(s0max));
        m_lfsr[c]   = galois(seed_of(c));
        m_level[c]  = 1'b0;
        m_forced[c] = 1'b0;
      end else if (md == 1 || md == 2) begin
        m_edge[c]   = (m_level[c] != (md == 2));
        m_level[c]  = (md == 2);
        m_forced[c] = 1'b1;
      end else if (en) begin
        if (m_forced[c]) begin
          m_forced[c] = 1'b0;
          draw(c, md, m_level[c], lim);
          m_rem[c] = lim;
        end else if (m_rem[c] == 0) begin
          m_level[c] = !m_level[c];
          m_edge[c]  = 1'b1;
          draw(c, md, m_level[c], lim);
          m_rem[c] = lim;
        end else begin
          m_rem[c]--;
        end
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  task automatic chk_range(input string nm, input int act, input int lo, input int hi);
    n_total++;
    if (act < lo || act > hi) $display("FAIL %s: got %0d expected %0d..%0d at %0t", nm, act, lo, hi, $time);
    else n_pass++;
  endtask

  task automatic tick();
    logic [CH-1:0] es, ee;
    model_step();
    for (int c = 0; c < CH; c++) begin
      es[c] = m_level[c];
      ee[c] = m_edge[c];
    end
    @(posedge clk);
    #1;
    chk("model_state", 32'(st), 32'(es));
    chk("model_edge", 32'(ed), 32'(ee));
    chk("cfg_err", 32'(err), 32'((s0min > s0max) || (s1min > s1max)));
  endtask

  task automatic set_bounds(input int a0, input int b0, input int a1, input int b1);
    s0min = CW'(a0); s0max = CW'(b0); s1min = CW'(a1); s1max = CW'(b1);
  endtask

  // Call right after a reset tick; checks every completed run length per channel.
  task automatic run_lengths(input int n, input int lo0, input int hi0, input int lo1, input int hi1);
    int run [CH];
    bit lvl [CH];
    for (int c = 0; c < CH; c++) begin
      run[c] = 1;
      lvl[c] = 1'b0;
    end
    repeat (n) begin
      tick();
      for (int c = 0; c < CH; c++) begin
        if (st[c] == lvl[c]) begin
          run[c]++;
        end else begin
          if (lvl[c]) chk_range("high_run", run[c], lo1, hi1);
          else        chk_range("low_run", run[c], lo0, hi0);
          lvl[c] = st[c];
          run[c] = 1;
        end
      end
    end
  endtask

  typedef struct {
    bit            r;
    bit            e;
    logic [2*CH-1:0] md;
    int            a0, b0, a1, b1;
    logic [CH-1:0] xs;
    logic [CH-1:0] xe;
    bit            xerr;
  } vec_t;

  vec_t tbl [20];

  logic [CH-1:0] prev;
  logic [CH-1:0] rec [60];
  bit            prev1;
  int            run1;

  initial begin
    rst = 1'b1; en = 1'b1; mode = '1;
    set_bounds(3, 3, 3, 3);

    // Fixed cadence, enable hold, config error flag and force/release.
    tbl[0]  = '{1'b1, 1'b1, 8'hFF,  3, 3, 3, 3, 4'h0, 4'h0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 8'hFF,  3, 3, 3, 3, 4'h0, 4'h0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 8'hFF,  3, 3, 3, 3, 4'h0, 4'h0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 8'hFF,  3, 3, 3, 3, 4'h0, 4'h0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 8'hFF,  3, 3, 3, 3, 4'hF, 4'hF, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 8'hFF,  3, 3, 3, 3, 4'hF, 4'h0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 8'hFF,  3, 3, 3, 3, 4'hF, 4'h0, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 8'hFF,  3, 3, 3, 3, 4'hF, 4'h0, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 8'hFF,  3, 3, 3, 3, 4'h0, 4'hF, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 8'hFF,  3, 3, 3, 3, 4'h0, 4'h0, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 8'hFF, 12, 4, 3, 3, 4'h0, 4'h0, 1'b1};
    tbl[11] = '{1'b0, 1'b1, 8'hFF,  3, 3, 3, 3, 4'h0, 4'h0, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 8'hAA,  3, 3, 3, 3, 4'hF, 4'hF, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 8'hAA,  3, 3, 3, 3, 4'hF, 4'h0, 1'b0};
    tbl[14] = '{1'b0, 1'b1, 8'h55,  3, 3, 3, 3, 4'h0, 4'hF, 1'b0};
    tbl[15] = '{1'b0, 1'b1, 8'hFF,  3, 3, 3, 3, 4'h0, 4'h0, 1'b0};
    tbl[16] = '{1'b0, 1'b1, 8'hFF,  3, 3, 3, 3, 4'h0, 4'h0, 1'b0};
    tbl[17] = '{1'b0, 1'b1, 8'hFF,  3, 3, 3, 3, 4'h0, 4'h0, 1'b0};
    tbl[18] = '{1'b0, 1'b1, 8'hFF,  3, 3, 3, 3, 4'h0, 4'h0, 1'b0};
    tbl[19] = '{1'b0, 1'b1, 8'hFF,  3, 3, 3, 3, 4'hF, 4'hF, 1'b0};

    for (int i = 0; i < 20; i++) begin
      rst = tbl[i].r; en = tbl[i].e; mode = tbl[i].md;
      set_bounds(tbl[i].a0, tbl[i].b0, tbl[i].a1, tbl[i].b1);
      tick();
      chk("tbl_state", 32'(st), 32'(tbl[i].xs));
      chk("tbl_edge", 32'(ed), 32'(tbl[i].xe));
      chk("tbl_cfg_err", 32'(err), 32'(tbl[i].xerr));
    end

    // Degenerate random: zero-length phases toggle every cycle.
    mode = '0; en = 1'b1; set_bounds(0, 0, 0, 0);
    rst = 1'b1; tick(); rst = 1'b0;
    prev = st;
    repeat (30) begin
      tick();
      chk("degen_edge", 32'(ed), 32'hF);
      chk("degen_toggle", 32'(st), 32'(prev ^ 4'hF));
      prev = st;
    end

    // Random bounds: low runs 3..10, high runs exactly 6.
    set_bounds(2, 9, 5, 5);
    rst = 1'b1; tick(); rst = 1'b0;
    run_lengths(10000, 3, 10, 6, 6);

    // Enable low mid-phase: nothing moves.
    en = 1'b0;
    prev = st;
    repeat (20) begin
      tick();
      chk("hold_state", 32'(st), 32'(prev));
      chk("hold_edge", 32'(ed), 32'h0);
    end
    en = 1'b1;

    // Force channel 1 high, then release to RANDOM: high phase restarts at counter 0.
    mode = 8'h08;
    prev1 = st[1];
    tick();
    chk("force_state1", 32'(st[1]), 32'h1);
    chk("force_edge1", 32'(ed[1]), 32'(!prev1));
    repeat (3) tick();
    mode = '0;
    tick();
    run1 = 0;
    while (st[1] === 1'b1 && run1 < 50) begin
      run1++;
      tick();
    end
    chk("restart_run1", 32'(run1), 32'd6);

    // Configuration error: low runs fixed at s0_min+1 in both FIXED and RANDOM.
    set_bounds(12, 4, 5, 5);
    mode = 8'h0F;
    rst = 1'b1; tick(); rst = 1'b0;
    chk("cfg_err_set", 32'(err), 32'h1);
    run_lengths(300, 13, 13, 6, 6);

    // Mid-operation reset replays the post-reset sequence.
    set_bounds(2, 9, 5, 5);
    mode = '0;
    rst = 1'b1; tick(); rst = 1'b0;
    rec[0] = st;
    for (int i = 1; i < 60; i++) begin
      tick();
      rec[i] = st;
    end
    for (int i = 0; i < 50 && st[0] !== 1'b1; i++) tick();
    chk("wait_high", 32'(st[0]), 32'h1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("midrst_state", 32'(st), 32'h0);
    chk("midrst_edge", 32'(ed), 32'h0);
    chk("replay", 32'(st), 32'(rec[0]));
    for (int i = 1; i < 60; i++) begin
      tick();
      chk("replay", 32'(st), 32'(rec[i]));
    end

    // Randomized stimulus against the model.
    set_bounds(1, 6, 0, 4);
    rst = 1'b1; tick(); rst = 1'b0;
    repeat (3000) begin
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 19) == 0) mode = 2*CH'($urandom);
      if ($urandom_range(0, 29) == 0)
        set_bounds($urandom_range(0, 15), $urandom_range(0, 15),
                   $urandom_range(0, 15), $urandom_range(0, 15));
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
